fpu_fround: RTL and testbench
=============================

FPU_FROUND -- requirements
Module: fpu_fround

Interface
REQ-001 SHALL have parameter TAG_W, default 5: tag width.
REQ-002 SHALL have parameter QNAN, default 32'h7FBFFFFF: default quiet-NaN encoding.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports i_valid (input, 1) and i_ready (output, 1): input handshake.
REQ-006 SHALL have port i_tag, input, TAG_W: opaque tag, returned unchanged.
REQ-007 SHALL have port i_rm, input, 1: rounding mode; 0 = nearest-even, 1 = toward zero.
REQ-008 SHALL have ports i_sign (1), i_exp (10, signed unbiased) and i_frac (47, hidden bit removed): value = (-1)^sign * 1.frac * 2^exp.
REQ-009 SHALL have inputs i_is_zero, i_is_inf, i_is_nan and i_invalid, 1 bit each: special-class and upstream invalid flags.
REQ-010 SHALL have ports o_valid (output, 1) and o_ready (input, 1): output handshake.
REQ-011 SHALL have ports o_tag (output, TAG_W) and o_result (output, 32): IEEE-754 single result.
REQ-012 SHALL have outputs o_inexact, o_overflow, o_underflow and o_invalid, 1 bit each: exception flags.

Function
REQ-013 SHALL be a 2-stage pipeline: S1 = bias, round decision; S2 = increment, renormalise, range check, pack.
REQ-014 SHALL accept an input on a cycle with i_valid && i_ready; the result SHALL appear 2 cycles later when unstalled.
REQ-015 SHALL drive i_ready = !o_valid || o_ready; when i_ready is low, both stages SHALL hold all contents.
REQ-016 SHALL keep o_valid and all outputs stable while o_valid && !o_ready, preserve order, and never drop or duplicate a result.
REQ-017 SHALL insert a bubble into the pipeline when i_valid is low during an advance.
REQ-018 SHALL sample i_rm together with its operand; a change to i_rm SHALL NOT affect operands already in flight.
REQ-019 SHALL compute biased exponent be = i_exp + 127, as an 11-bit signed value.
REQ-020 SHALL round using mant = frac[46:24], guard g = frac[23] and sticky s = |frac[22:0].
REQ-021 SHALL increment the mantissa only when rm = 0 && g && (s || mant[0]).
REQ-022 SHALL, on mantissa carry-out, set the mantissa to 0 and increment be.
REQ-023 SHALL set o_inexact = g || s for finite non-zero results.
REQ-024 SHALL treat be >= 255 after rounding as overflow: result is signed infinity if rm = 0, else signed 0x7F7FFFFF; o_overflow = o_inexact = 1.
REQ-025 SHALL treat be <= 0 as underflow: result is signed zero, flushing denormals; o_underflow = o_inexact = 1.
REQ-026 SHALL apply special-class priority nan > inf > zero > finite.
REQ-027 SHALL output QNAN for NaN inputs, sign ignored, with only o_invalid = i_invalid raised.
REQ-028 SHALL output {sign, 8'hFF, 0} for infinity inputs and {sign, 31'b0} for zero inputs, with no flags raised.
REQ-029 SHALL pass i_invalid through to o_invalid for every class.

Reset
REQ-030 SHALL, while rst_n is low, clear both stage valid bits, o_valid, o_result, o_tag and all flags to 0, independent of clk.
REQ-031 SHALL discard in-flight operations when reset is asserted mid-operation.
REQ-032 SHALL present i_ready = 1 in the first cycle after reset deassertion.

Structure
REQ-033 SHALL take BIAS (127), EXP_INF (255), MAX_FINITE (0x7F7FFFFF) and the rounding-mode encoding from shared package fpu_pkg.
REQ-034 SHALL place the S1 increment decision (mant LSB, g, s, rm -> inc, inexact) in one combinational sub-module, fpu_round_decide.

Verification
REQ-035 SHALL cover: exp = 0, frac = 0, rm = 0 -> 0x3F800000, no flags, latency 2.
REQ-036 SHALL cover: exp = 0, frac[46:23] all ones, rest 0 -> rm = 0 gives 0x40000000, inexact; rm = 1 gives 0x3FFFFFFF, inexact.
REQ-037 SHALL cover: exp = 128, sign = 1 -> rm = 0 gives 0xFF800000; rm = 1 gives 0xFF7FFFFF; overflow and inexact set in both cases.
REQ-038 SHALL cover: exp = -127 -> 0x00000000, underflow and inexact set; is_nan with invalid = 1 -> 0x7FBFFFFF, o_invalid = 1.
REQ-039 SHALL cover: 3 back-to-back inputs (tags 1, 2, 3) with o_ready low for 4 cycles -> i_ready low, outputs held, then tags 1, 2, 3 delivered in order.
REQ-040 SHALL cover: rst_n asserted with 2 operations in flight -> o_valid = 0 immediately, no stale result after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared single-precision constants and rounding-mode encoding for the FPU datapath.
package fpu_pkg;

  localparam logic signed [10:0] BIAS       = 11'sd127;
  localparam logic signed [10:0] EXP_INF    = 11'sd255;
  localparam logic [31:0]        MAX_FINITE = 32'h7F7FFFFF;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic invalid;
  } fp_class_t;

endpackage

// File: rtl/fpu_round_decide.sv
// Round-to-nearest-even / truncate increment decision from mantissa LSB, guard and sticky.
module fpu_round_decide
  import fpu_pkg::*;
(
  input  logic lsb,
  input  logic g,
  input  logic s,
  input  logic rm,
  output logic inc,
  output logic inexact
);

  assign inc     = (rm == RM_RNE) && g && (s || lsb);
  assign inexact = g || s;

endmodule

// File: rtl/fpu_fround.sv
// Two-stage single-precision rounder/packer with valid/ready flow control and flush-to-zero.
module fpu_fround
  import fpu_pkg::*;
#(
  parameter int          TAG_W = 5,
  parameter logic [31:0] QNAN  = 32'h7FBFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_rm,
  input  logic             i_sign,
  input  logic [9:0]       i_exp,
  input  logic [46:0]      i_frac,
  input  logic             i_is_zero,
  input  logic             i_is_inf,
  input  logic             i_is_nan,
  input  logic             i_invalid,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_result,
  output logic             o_inexact,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic             o_invalid
);

  function automatic logic [31:0] sat_result(input logic sign, input logic rm);
    if (rm == RM_RTZ) return {sign, MAX_FINITE[30:0]};
    return {sign, 8'hFF, 23'h0};
  endfunction

  logic advance;
  assign i_ready = !o_valid || o_ready;
  assign advance = i_ready;

  logic inc_d, inx_d;
  fpu_round_decide u_round_decide (
    .lsb    (i_frac[24]),
    .g      (i_frac[23]),
    .s      (|i_frac[22:0]),
    .rm     (i_rm),
    .inc    (inc_d),
    .inexact(inx_d)
  );

  // S1: bias exponent, latch round decision and class
  logic                    vld_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic                    rm_p1, sign_p1, inc_p1, inx_p1;
  logic signed [10:0]      be_p1;
  logic [22:0]             mant_p1;
  fp_class_t               cls_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= i_valid;
  end

  always_ff @(posedge clk) begin
    if (advance && i_valid) begin
      tag_p1  <= i_tag;
      rm_p1   <= i_rm;
      sign_p1 <= i_sign;
      be_p1   <= $signed({i_exp[9], i_exp}) + BIAS;
      mant_p1 <= i_frac[46:24];
      inc_p1  <= inc_d;
      inx_p1  <= inx_d;
      cls_p1  <= '{is_zero: i_is_zero, is_inf: i_is_inf, is_nan: i_is_nan, invalid: i_invalid};
    end
  end

  // S2: increment, renormalise, range check, pack
  logic [23:0]        mant_sum;
  logic signed [10:0] be_rnd;
  logic [31:0]        result_d;
  logic               inexact_d, overflow_d, underflow_d;

  assign mant_sum = {1'b0, mant_p1} + {23'h0, inc_p1};
  assign be_rnd   = be_p1 + (mant_sum[23] ? 11'sd1 : 11'sd0);

  always_comb begin
    result_d    = {sign_p1, be_rnd[7:0], mant_sum[22:0]};
    inexact_d   = inx_p1;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (cls_p1.is_nan) begin
      result_d  = QNAN;
      inexact_d = 1'b0;
    end else if (cls_p1.is_inf) begin
      result_d  = {sign_p1, 8'hFF, 23'h0};
      inexact_d = 1'b0;
    end else if (cls_p1.is_zero) begin
      result_d  = {sign_p1, 31'h0};
      inexact_d = 1'b0;
    end else if (be_rnd >= EXP_INF) begin
      result_d   = sat_result(sign_p1, rm_p1);
      inexact_d  = 1'b1;
      overflow_d = 1'b1;
    end else if (be_rnd <= 11'sd0) begin
      result_d    = {sign_p1, 31'h0};
      inexact_d   = 1'b1;
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid     <= 1'b0;
      o_tag       <= '0;
      o_result    <= '0;
      o_inexact   <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_invalid   <= 1'b0;
    end else if (advance) begin
      o_valid <= vld_p1;
      if (vld_p1) begin
        o_tag       <= tag_p1;
        o_result    <= result_d;
        o_inexact   <= inexact_d;
        o_overflow  <= overflow_d;
        o_underflow <= underflow_d;
        o_invalid   <= cls_p1.invalid;
      end
    end
  end

endmodule

// File: tb/tb_fpu_fround.sv
// Randomized scoreboard bench for fpu_fround with directed corner cases, stall and reset checks.
module tb_fpu_fround;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_ready;
  logic [4:0]  i_tag = '0;
  logic        i_rm = 1'b0, i_sign = 1'b0;
  logic [9:0]  i_exp = '0;
  logic [46:0] i_frac = '0;
  logic        i_is_zero = 1'b0, i_is_inf = 1'b0, i_is_nan = 1'b0, i_invalid = 1'b0;
  logic        o_valid, o_ready = 1'b1;
  logic [4:0]  o_tag;
  logic [31:0] o_result;
  logic        o_inexact, o_overflow, o_underflow, o_invalid;

  always #5 clk = ~clk;

  fpu_fround #(.TAG_W(5), .QNAN(32'h7FBFFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_tag(i_tag),
    .i_rm(i_rm), .i_sign(i_sign), .i_exp(i_exp), .i_frac(i_frac),
    .i_is_zero(i_is_zero), .i_is_inf(i_is_inf), .i_is_nan(i_is_nan), .i_invalid(i_invalid),
    .o_valid(o_valid), .o_ready(o_ready), .o_tag(o_tag), .o_result(o_result),
    .o_inexact(o_inexact), .o_overflow(o_overflow), .o_underflow(o_underflow), .o_invalid(o_invalid)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0, n_out = 0;
  logic [31:0] last_res;
  logic [3:0]  last_flg;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: exact significand arithmetic on the real value, then IEEE packing rules
  function automatic exp_t model(bit s, logic [9:0] e, logic [46:0] f, bit r, bit z, bit fi,
                                 bit fn, bit inv, logic [4:0] t);
    exp_t        x;
    logic [47:0] sig;
    logic [24:0] qv;
    logic [23:0] rem;
    int          be;
    x.tag = t;
    x.flg = {3'b000, inv};
    if (fn) x.res = 32'h7FBFFFFF;
    else if (fi) x.res = {s, 8'hFF, 23'h0};
    else if (z) x.res = {s, 31'h0};
    else begin
      sig = {1'b1, f};
      qv  = {1'b0, sig[47:24]};
      rem = sig[23:0];
      if (!r && (rem > 24'h800000 || (rem == 24'h800000 && qv[0]))) qv = qv + 25'd1;
      be = int'($signed(e)) + 127;
      if (qv[24]) begin
        qv = qv >> 1;
        be++;
      end
      if (be >= 255) begin
        x.res = r ? {s, 31'h7F7FFFFF} : {s, 8'hFF, 23'h0};
        x.flg[3:2] = 2'b11;
      end else if (be <= 0) begin
        x.res = {s, 31'h0};
        x.flg[3] = 1'b1;
        x.flg[1] = 1'b1;
      end else begin
        x.res = {s, 8'(be), qv[22:0]};
        x.flg[3] = (rem != 24'h0);
      end
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (i_valid && i_ready)
        sb.push_back(model(i_sign, i_exp, i_frac, i_rm, i_is_zero, i_is_inf, i_is_nan, i_invalid, i_tag));
      if (o_valid && o_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          exp_t x;
          x = sb.pop_front();
          chk("result", o_result, x.res);
          chk("flags", {28'h0, o_inexact, o_overflow, o_underflow, o_invalid}, {28'h0, x.flg});
          chk("tag", {27'h0, o_tag}, {27'h0, x.tag});
        end
        last_res = o_result;
        last_flg = {o_inexact, o_overflow, o_underflow, o_invalid};
        n_out++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) o_ready = ($urandom % 4) != 0;
  endtask

  task automatic drive(bit s, logic [9:0] e, logic [46:0] f, bit r, bit z, bit fi, bit fn,
                       bit inv, logic [4:0] t);
    i_sign = s; i_exp = e; i_frac = f; i_rm = r;
    i_is_zero = z; i_is_inf = fi; i_is_nan = fn; i_invalid = inv; i_tag = t;
    i_valid = 1'b1;
  endtask

  task automatic send(bit s, logic [9:0] e, logic [46:0] f, bit r, bit z, bit fi, bit fn,
                      bit inv, logic [4:0] t);
    bit done = 1'b0;
    int n = 0;
    drive(s, e, f, r, z, fi, fn, inv, t);
    while (!done) begin
      @(negedge clk);
      done = i_ready;
      tick();
      n++;
      if (!done && n > 200) begin
        chk("send_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic directed(string nm, bit s, logic [9:0] e, logic [46:0] f, bit r, bit z, bit fi,
                          bit fn, bit inv, logic [31:0] wres, logic [3:0] wflg);
    int n0 = n_out;
    int n = 0;
    send(s, e, f, r, z, fi, fn, inv, 5'd9);
    i_valid = 1'b0;
    while (n_out == n0 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_seen"}, 32'(n_out - n0), 32'd1);
    chk(nm, last_res, wres);
    chk({nm, "_flg"}, {28'h0, last_flg}, {28'h0, wflg});
  endtask

  initial begin
    logic [31:0] held;
    int n;
    #2;
    chk("rst_o_valid", {31'h0, o_valid}, 32'd0);
    chk("rst_o_result", o_result, 32'd0);
    chk("rst_o_tag", {27'h0, o_tag}, 32'd0);
    chk("rst_flags", {28'h0, o_inexact, o_overflow, o_underflow, o_invalid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'h0, i_ready}, 32'd1);

    // exp=0, frac=0: check exact latency of 2
    drive(1'b0, 10'd0, 47'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
    tick();
    i_valid = 1'b0;
    chk("lat_cycle1_valid", {31'h0, o_valid}, 32'd0);
    tick();
    chk("lat_cycle2_valid", {31'h0, o_valid}, 32'd1);
    chk("lat_one", o_result, 32'h3F800000);
    chk("lat_one_flg", {28'h0, o_inexact, o_overflow, o_underflow, o_invalid}, 32'd0);
    tick();

    directed("rne_carry", 1'b0, 10'd0, 47'h7FFFFF800000, 1'b0, 0, 0, 0, 0, 32'h40000000, 4'b1000);
    directed("rtz_trunc", 1'b0, 10'd0, 47'h7FFFFF800000, 1'b1, 0, 0, 0, 0, 32'h3FFFFFFF, 4'b1000);
    directed("ovf_rne", 1'b1, 10'd128, 47'h0, 1'b0, 0, 0, 0, 0, 32'hFF800000, 4'b1100);
    directed("ovf_rtz", 1'b1, 10'd128, 47'h0, 1'b1, 0, 0, 0, 0, 32'hFF7FFFFF, 4'b1100);
    directed("unf", 1'b0, 10'h381, 47'h0, 1'b0, 0, 0, 0, 0, 32'h00000000, 4'b1010);
    directed("nan", 1'b1, 10'd5, 47'h123, 1'b0, 0, 0, 1, 1, 32'h7FBFFFFF, 4'b0001);
    directed("inf", 1'b1, 10'd5, 47'h123, 1'b0, 0, 1, 0, 0, 32'hFF800000, 4'b0000);
    directed("zero", 1'b1, 10'd5, 47'h123, 1'b0, 1, 0, 0, 0, 32'h80000000, 4'b0000);

    // Back-to-back with output stalled for 4 cycles
    o_ready = 1'b0;
    send(1'b0, 10'd1, 47'h1, 1'b0, 0, 0, 0, 0, 5'd1);
    send(1'b0, 10'd2, 47'h2, 1'b0, 0, 0, 0, 0, 5'd2);
    drive(1'b0, 10'd3, 47'h3, 1'b0, 0, 0, 0, 0, 5'd3);
    held = o_result;
    for (int k = 0; k < 4; k++) begin
      chk("stall_i_ready", {31'h0, i_ready}, 32'd0);
      chk("stall_o_valid", {31'h0, o_valid}, 32'd1);
      chk("stall_o_tag", {27'h0, o_tag}, 32'd1);
      chk("stall_o_result", o_result, held);
      tick();
    end
    o_ready = 1'b1;
    send(1'b0, 10'd3, 47'h3, 1'b0, 0, 0, 0, 0, 5'd3);
    i_valid = 1'b0;
    repeat (4) tick();
    chk("stall_drain", 32'(sb.size()), 32'd0);

    // Randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom % 4 == 0) begin
        i_valid = 1'b0;
        tick();
      end else begin
        logic [9:0]  e;
        logic [46:0] f;
        int          ev;
        ev = int'($urandom_range(0, 300)) - 150;
        e  = ($urandom % 8 == 0) ? 10'($urandom) : ev[9:0];
        f  = {15'($urandom), $urandom};
        if ($urandom % 8 == 0) f[23:0] = 24'h800000;
        send(1'($urandom), e, f, 1'($urandom), ($urandom % 16) == 0, ($urandom % 16) == 0,
             ($urandom % 16) == 0, 1'($urandom), 5'($urandom));
      end
    end
    i_valid = 1'b0;
    rnd_ready = 1'b0;
    o_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("rand_drain", 32'(sb.size()), 32'd0);

    // Reset with two operations in flight
    o_ready = 1'b0;
    send(1'b0, 10'd6, 47'h6, 1'b0, 0, 0, 0, 0, 5'd6);
    send(1'b0, 10'd7, 47'h7, 1'b0, 0, 0, 0, 0, 5'd7);
    i_valid = 1'b0;
    chk("pre_rst_valid", {31'h0, o_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", {31'h0, o_valid}, 32'd0);
    chk("midrst_o_result", o_result, 32'd0);
    chk("midrst_o_tag", {27'h0, o_tag}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_midrst", {31'h0, i_ready}, 32'd1);
    o_ready = 1'b1;
    n = n_out;
    repeat (8) tick();
    chk("no_stale_out", 32'(n_out - n), 32'd0);
    chk("no_stale_valid", {31'h0, o_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
